sr_receive: RTL and testbench
=============================

Name: sr_receive

Overview:
- Serial-to-parallel receive shift register: collects D serial bits and presents them as one parallel word with a valid/acknowledge handshake.
- It is the receiving end of the SR transmit path in the 2d-flattening/randomization datapath. The transmit side drives flattened matrix rows out as D-bit words; this block rebuilds them at the consumer.
- Purely synchronous to clk, except for the asynchronous reset.

Parameters:
- D, 8, word width in bits; legal range 2..32.
- MSB_FIRST, 1, bit order. 1: first received bit lands in out[D-1]. 0: first received bit lands in out[0].

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous reset, active-low (rst==0 resets immediately, independent of clk).
- sin  input  1  serial data bit.
- sin_en  input  1  sin is valid this cycle.
- start  input  1  qualifies the current sin_en bit as bit 0 of a new word; ignored when sin_en=0.
- out_ack  input  1  consumer accepts out this cycle.
- clr  input  1  synchronous clear of the sticky error flags.
- out  output  D  last completed word.
- out_valid  output  1  out holds an unacknowledged word.
- busy  output  1  a word is partially received.
- ovr  output  1  sticky overrun flag.
- ferr  output  1  sticky framing-error flag.

Behaviour:
- Reset (rst low, async): state=IDLE, bit counter=0, shift register=0. All outputs are 0: out, out_valid, busy, ovr, ferr.
- Reset mid-word discards the partial word; no out_valid is produced for it.
- Two states, IDLE and SHIFT. Bit counter width is $clog2(D).
- Bits are accepted only on cycles with sin_en=1; cycles with sin_en=0 are gaps and change nothing.
- IDLE:
  - sin_en=1 and start=1: capture sin as bit 0, cnt=1, go to SHIFT.
  - sin_en=1 and start=0: bit dropped, ferr<=1.
- SHIFT:
  - Each sin_en=1 with start=0 shifts in sin and increments cnt.
  - The accepted bit that makes cnt reach D completes the word. On that clock edge: out<=assembled word, out_valid<=1, cnt<=0, state<=IDLE.
  - out therefore updates on the same edge that samples the Dth bit; observable one cycle after the Dth bit is presented.
- start=1 with sin_en=1 while in SHIFT: the partial word is discarded, ferr<=1, and the bit is taken as bit 0 of a new word (cnt=1, stay in SHIFT).
- Bit order:
  - MSB_FIRST=1: shift left, new bit into LSB of the register; D bits in arrival order map to out[D-1..0].
  - MSB_FIRST=0: shift right, new bit into MSB; the first bit ends at out[0].
- busy=1 exactly when state==SHIFT.
- Handshake:
  - out_valid stays high until a clock edge with out_ack=1; that edge clears it.
  - out is stable while out_valid=1, unless overwritten by an overrun.
  - out_ack while out_valid=0 is ignored.
- Overrun: a word completes while out_valid=1 and out_ack=0. The new word overwrites out, out_valid stays 1, ovr<=1.
- Word completion and out_ack on the same edge: the new word loads, out_valid stays 1, no ovr.
- Sticky flags: ovr and ferr hold until rst or clr=1.
  - If clr and a new error event occur on the same edge, the error wins and the flag stays 1.
- No combinational path from inputs to outputs; all outputs are registered.

Decomposition:
- Shared package (sr_pkg):
  - State encoding constants: ST_IDLE=1'b0, ST_SHIFT=1'b1.
  - Default word width constant SR_D=8, shared with the transmit side.
  - Bit-order constants.
- Natural sub-module: sr_out_hold, the output register plus the out_valid/out_ack/ovr handshake logic.
  - Kept separate so the transmit side's consumers can reuse it.
- The shift register, counter and FSM stay in sr_receive.

Test Plan:
- Basic word: D=8, MSB_FIRST=1, bits 1,0,1,0,0,1,0,1, start on the first bit, sin_en continuous -> out=8'hA5 and out_valid=1 after the 8th edge; busy=1 for 7 cycles, then 0.
- Gaps and LSB-first: MSB_FIRST=0, same bit stream with sin_en=0 gaps of 0–3 cycles between bits -> out=8'hA5 (first bit at out[0]); gap cycles leave cnt unchanged.
- Overrun and same-edge ack:
  - Receive 8'h3C, hold out_ack=0, receive 8'hC3 -> out=8'hC3, ovr=1.
  - clr, then receive 8'h55 with out_ack=1 on its completion edge -> out=8'h55, out_valid=1, ovr=0.
- Framing: start after 3 bits of a word, then 8 bits for 8'h0F -> ferr=1, out=8'h0F. A sin_en bit in IDLE without start -> ferr=1, no word produced.
- Async reset mid-word: drop rst low after 5 bits, between clock edges -> out, out_valid, busy, cnt all 0 immediately. After release, a full 8'hFF word is received correctly.
- Handshake hold: word 8'h81 with out_ack held low for 10 cycles -> out_valid and out stable throughout; the out_ack pulse clears out_valid on the next edge.

Source files
------------

// File: rtl/sr_pkg.sv
// Shared definitions for the SR transmit/receive path: state encoding,
// default word width and bit-order selectors.
package sr_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } sr_state_t;

    localparam int SR_D         = 8;
    localparam bit SR_MSB_FIRST = 1'b1;
    localparam bit SR_LSB_FIRST = 1'b0;

endpackage

// File: rtl/sr_out_hold.sv
// Parallel output holding register with valid/acknowledge handshake and a
// sticky overrun flag (set when a new word lands on an unacknowledged one).
module sr_out_hold #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] word,
    input  logic         ack,
    input  logic         clr,
    output logic [W-1:0] out,
    output logic         out_valid,
    output logic         ovr
);

    logic [W-1:0] out_reg, out_next;
    logic         valid_reg, valid_next;
    logic         ovr_reg, ovr_next;
    logic         ovr_event;

    always_comb begin
        out_next   = out_reg;
        valid_next = valid_reg;
        ovr_event  = 1'b0;
        if (load) begin
            out_next   = word;
            valid_next = 1'b1;
            // A same-edge ack consumes the old word, so no data is lost
            ovr_event  = valid_reg & ~ack;
        end else if (ack) begin
            valid_next = 1'b0;
        end
        ovr_next = ovr_event | (ovr_reg & ~clr);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_reg   <= '0;
            valid_reg <= 1'b0;
            ovr_reg   <= 1'b0;
        end else begin
            out_reg   <= out_next;
            valid_reg <= valid_next;
            ovr_reg   <= ovr_next;
        end
    end

    assign out       = out_reg;
    assign out_valid = valid_reg;
    assign ovr       = ovr_reg;

endmodule

// File: rtl/sr_receive.sv
// Serial-to-parallel receiver: assembles D bits qualified by sin_en into a
// word, framed by start, and hands it to sr_out_hold.
module sr_receive
    import sr_pkg::*;
#(
    parameter int D         = SR_D,
    parameter bit MSB_FIRST = SR_MSB_FIRST
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         sin,
    input  logic         sin_en,
    input  logic         start,
    input  logic         out_ack,
    input  logic         clr,
    output logic [D-1:0] out,
    output logic         out_valid,
    output logic         busy,
    output logic         ovr,
    output logic         ferr
);

    localparam int CW = $clog2(D);

    sr_state_t       state_reg, state_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    // Only D-1 bits are ever pending; the Dth bit goes straight into the word
    logic [D-2:0]    part_reg, part_next;
    logic [D-2:0]    part_start, part_shift;
    logic [D-1:0]    word;
    logic            ferr_reg, ferr_next;
    logic            frame_err;
    logic            word_load;

    generate
        for (genvar gi = 0; gi < D - 1; gi++) begin : g_shift
            if (MSB_FIRST) begin : g_msb
                if (gi == 0) begin : g_in
                    assign part_start[gi] = sin;
                    assign part_shift[gi] = sin;
                end else begin : g_mv
                    assign part_start[gi] = 1'b0;
                    assign part_shift[gi] = part_reg[gi-1];
                end
            end else begin : g_lsb
                if (gi == D - 2) begin : g_in
                    assign part_start[gi] = sin;
                    assign part_shift[gi] = sin;
                end else begin : g_mv
                    assign part_start[gi] = 1'b0;
                    assign part_shift[gi] = part_reg[gi+1];
                end
            end
        end
        if (MSB_FIRST) begin : g_word_msb
            assign word = {part_reg, sin};
        end else begin : g_word_lsb
            assign word = {sin, part_reg};
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        part_next  = part_reg;
        frame_err  = 1'b0;
        word_load  = 1'b0;
        if (sin_en) begin
            if (start) begin
                // A start inside a word abandons it and resynchronises here
                frame_err  = (state_reg == ST_SHIFT);
                part_next  = part_start;
                cnt_next   = CW'(1);
                state_next = ST_SHIFT;
            end else if (state_reg == ST_IDLE) begin
                frame_err = 1'b1;
            end else if (cnt_reg == CW'(D - 1)) begin
                word_load  = 1'b1;
                part_next  = '0;
                cnt_next   = '0;
                state_next = ST_IDLE;
            end else begin
                part_next = part_shift;
                cnt_next  = cnt_reg + CW'(1);
            end
        end
        ferr_next = frame_err | (ferr_reg & ~clr);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            part_reg  <= '0;
            ferr_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            part_reg  <= part_next;
            ferr_reg  <= ferr_next;
        end
    end

    assign busy = (state_reg == ST_SHIFT);
    assign ferr = ferr_reg;

    sr_out_hold #(
        .W(D)
    ) u_out_hold (
        .clk      (clk),
        .rst      (rst),
        .load     (word_load),
        .word     (word),
        .ack      (out_ack),
        .clr      (clr),
        .out      (out),
        .out_valid(out_valid),
        .ovr      (ovr)
    );

endmodule

// File: tb/tb_sr_receive.sv
// Bench for sr_receive: MSB-first and LSB-first instances share stimulus and
// are compared every cycle against a queue-based reference model.
module tb_sr_receive;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sin = 1'b0;
    logic       sin_en = 1'b0;
    logic       start = 1'b0;
    logic       out_ack = 1'b0;
    logic       clr = 1'b0;

    logic [7:0] out_m, out_l;
    logic       val_m, val_l, busy_m, busy_l, ovr_m, ovr_l, ferr_m, ferr_l;

    always #5 clk = ~clk;

    sr_receive #(.D(8), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst(rst), .sin(sin), .sin_en(sin_en), .start(start),
        .out_ack(out_ack), .clr(clr), .out(out_m), .out_valid(val_m),
        .busy(busy_m), .ovr(ovr_m), .ferr(ferr_m)
    );

    sr_receive #(.D(8), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst(rst), .sin(sin), .sin_en(sin_en), .start(start),
        .out_ack(out_ack), .clr(clr), .out(out_l), .out_valid(val_l),
        .busy(busy_l), .ovr(ovr_l), .ferr(ferr_l)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: pending bits of the current word in arrival order
    int         q[$];
    logic [7:0] m_out_m, m_out_l;
    bit         m_valid, m_ovr, m_ferr;

    task automatic model_reset();
        q.delete();
        m_out_m = '0;
        m_out_l = '0;
        m_valid = 1'b0;
        m_ovr   = 1'b0;
        m_ferr  = 1'b0;
    endtask

    task automatic model_step(input bit en, input bit st, input bit b, input bit ack, input bit cl);
        bit         done = 1'b0;
        bit         fe = 1'b0;
        bit         oe = 1'b0;
        logic [7:0] wm = '0;
        logic [7:0] wl = '0;
        if (en) begin
            if (st) begin
                if (q.size() > 0) fe = 1'b1;
                q.delete();
                q.push_back(int'(b));
            end else if (q.size() == 0) begin
                fe = 1'b1;
            end else begin
                q.push_back(int'(b));
                if (q.size() == 8) done = 1'b1;
            end
        end
        if (done) begin
            for (int i = 0; i < 8; i++) begin
                wm = 8'((wm << 1) | q[i]);
                wl = wl | 8'(q[i] << i);
            end
            q.delete();
            oe      = m_valid && !ack;
            m_out_m = wm;
            m_out_l = wl;
            m_valid = 1'b1;
        end else if (ack) begin
            m_valid = 1'b0;
        end
        m_ferr = fe | (m_ferr & !cl);
        m_ovr  = oe | (m_ovr & !cl);
    endtask

    task automatic compare_all();
        check("out_msb",  out_m,  m_out_m);
        check("out_lsb",  out_l,  m_out_l);
        check("valid_msb", val_m, m_valid);
        check("valid_lsb", val_l, m_valid);
        check("busy_msb", busy_m, q.size() != 0);
        check("busy_lsb", busy_l, q.size() != 0);
        check("ovr_msb",  ovr_m,  m_ovr);
        check("ovr_lsb",  ovr_l,  m_ovr);
        check("ferr_msb", ferr_m, m_ferr);
        check("ferr_lsb", ferr_l, m_ferr);
    endtask

    task automatic cyc(input bit en, input bit st, input bit b, input bit ack, input bit cl);
        sin_en  = en;
        start   = st;
        sin     = b;
        out_ack = ack;
        clr     = cl;
        @(posedge clk);
        model_step(en, st, b, ack, cl);
        #1;
        compare_all();
    endtask

    // Sends w in transmit order (w[7] first) with random 0..gmax idle gaps
    task automatic send_word(input logic [7:0] w, input int gmax, input bit ack_last);
        for (int i = 0; i < 8; i++) begin
            int gaps = (gmax > 0) ? int'($urandom_range(gmax, 0)) : 0;
            for (int g = 0; g < gaps; g++) cyc(1'b0, 1'b0, 1'($urandom), 1'b0, 1'b0);
            cyc(1'b1, i == 0, w[7-i], (i == 7) && ack_last, 1'b0);
        end
    endtask

    task automatic async_reset();
        #3;
        rst = 1'b0;
        #1;
        model_reset();
        check("arst_out",   out_m,  8'h00);
        check("arst_valid", val_m,  1'b0);
        check("arst_busy",  busy_m, 1'b0);
        compare_all();
        #1;
        rst = 1'b1;
    endtask

    initial begin
        model_reset();
        #1 rst = 1'b0;
        #1 compare_all();
        @(posedge clk);
        #1 rst = 1'b1;
        compare_all();

        // Basic word, continuous sin_en
        send_word(8'hA5, 0, 1'b0);
        check("basic_msb_a5", out_m, 8'hA5);
        check("basic_lsb_a5", out_l, 8'hA5);
        check("basic_valid", val_m, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Gapped stream
        send_word(8'hA5, 3, 1'b0);
        check("gap_lsb_a5", out_l, 8'hA5);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Overrun, then clear and same-edge ack
        send_word(8'h3C, 1, 1'b0);
        send_word(8'hC3, 1, 1'b0);
        check("ovr_out_c3", out_m, 8'hC3);
        check("ovr_flag", ovr_m, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        send_word(8'h55, 0, 1'b1);
        check("sameack_out", out_m, 8'h55);
        check("sameack_valid", val_m, 1'b1);
        check("sameack_ovr", ovr_m, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Framing: restart after 3 bits, then a stray bit in IDLE
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        send_word(8'h0F, 0, 1'b0);
        check("frame_ferr", ferr_m, 1'b1);
        check("frame_out", out_m, 8'h0F);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        check("ferr_cleared", ferr_m, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        check("idle_bit_ferr", ferr_m, 1'b1);
        check("idle_bit_novalid", val_m, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Asynchronous reset after 5 bits
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'($urandom), 1'b0, 1'b0);
        async_reset();
        send_word(8'hFF, 0, 1'b0);
        check("post_rst_ff", out_m, 8'hFF);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Hold without acknowledge
        send_word(8'h81, 0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0, 1'b0, 1'($urandom), 1'b0, 1'b0);
            check("hold_out", out_m, 8'h81);
            check("hold_valid", val_m, 1'b1);
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("ack_clears", val_m, 1'b0);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            bit en = ($urandom_range(9, 0) < 7);
            bit st = (q.size() == 0) ? ($urandom_range(3, 0) != 0) : ($urandom_range(15, 0) == 0);
            if ($urandom_range(499, 0) == 0) async_reset();
            cyc(en, st, 1'($urandom), $urandom_range(3, 0) == 0, $urandom_range(19, 0) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
